pipeline_control: RTL

- Central stall/flush sequencer for the 5-stage LC-3b pipeline (IF, ID, EX, MEM, WB).
- Drives PC load and the load/NOP/squash/flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB latches.
- Decides from I-cache/D-cache handshakes, load-use hazards and MEM-stage control transfers.
- Holds a small FSM that covers post-reset fill and pending redirects.

---
 rtl/pipeline_control_pkg.sv | 76 +++++++
 rtl/pipeline_control_if.sv | 59 +++++
 rtl/pipeline_control_load_use_detect.sv | 33 +++
 rtl/pipeline_control.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_control_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_control_pkg
//   Shared LC-3b pipeline-control types: register index, NOP encoding,
//   sequencer FSM states and the bundle of latch control strobes, plus
//   helpers that build the fixed control patterns used by the sequencer.
//   No ports (package).
// -----------------------------------------------------------------------------
package pipeline_control_pkg;

  // 3-bit architectural register index R0..R7.
  typedef logic [2:0]  lc3b_reg;
  typedef logic [15:0] lc3b_word;

  // All-zero word is the pipeline NOP (squashed IF/ID, flushed ID/EX, EX/MEM).
  localparam lc3b_word NOP = 16'h0000;

  typedef enum logic [1:0] {
    INIT       = 2'd0,  // post-reset fill, IF/ID contents not yet meaningful
    RUN        = 2'd1,  // normal operation
    DMEM_WAIT  = 2'd2,  // frozen on an outstanding data access
    REDIR_WAIT = 2'd3   // taken branch in MEM waiting for the fetch to finish
  } pipe_ctrl_state_t;

  // One strobe per latch control, in pipeline order.
  typedef struct packed {
    logic load_pc;
    logic load_if_id;
    logic inject_nop_if_id;
    logic squash_if_id;
    logic load_id_ex;
    logic flush_id_ex;
    logic load_ex_mem;
    logic flush_ex_mem;
    logic load_mem_wb;
  } pipe_ctrl_t;

  // Pattern driven while reset is asserted: NOPs everywhere, nothing loads.
  function automatic pipe_ctrl_t ctrl_reset();
    pipe_ctrl_t c;
    c = '0;
    c.inject_nop_if_id = 1'b1;
    c.flush_id_ex      = 1'b1;
    c.flush_ex_mem     = 1'b1;
    return c;
  endfunction

  // Applied redirect: new PC, IF/ID squashed, ID/EX and EX/MEM flushed
  // (flush loads the zero NOP, so the matching load is also raised) and the
  // MEM-stage control transfer retires into MEM/WB.
  function automatic pipe_ctrl_t ctrl_redirect();
    pipe_ctrl_t c;
    c = '0;
    c.load_pc      = 1'b1;
    c.load_if_id   = 1'b1;
    c.squash_if_id = 1'b1;
    c.load_id_ex   = 1'b1;
    c.flush_id_ex  = 1'b1;
    c.load_ex_mem  = 1'b1;
    c.flush_ex_mem = 1'b1;
    c.load_mem_wb  = 1'b1;
    return c;
  endfunction

  // Everything advances, no bubbles.
  function automatic pipe_ctrl_t ctrl_normal();
    pipe_ctrl_t c;
    c = '0;
    c.load_pc     = 1'b1;
    c.load_if_id  = 1'b1;
    c.load_id_ex  = 1'b1;
    c.load_ex_mem = 1'b1;
    c.load_mem_wb = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_control_if.sv
// -----------------------------------------------------------------------------
// pipeline_control_if
//   Bundles the pipeline status inputs and latch control outputs of the
//   stall/flush sequencer.
//
//   Handshake semantics: imem_resp means the instruction fetch issued for
//   the current PC completes in this cycle. dmem_req is held high by the
//   MEM stage for as long as its access is outstanding; the access completes
//   in the cycle where dmem_req and dmem_resp are both high. A response
//   without a request is ignored. br_taken_mem is held while the branch sits
//   in MEM; MEM is frozen until the redirect is applied.
//
//   modport master : datapath side (drives status, receives controls)
//   modport slave  : sequencer side (pipeline_control)
// -----------------------------------------------------------------------------
interface pipeline_control_if;
  import pipeline_control_pkg::*;

  // Status from the datapath / caches
  logic    imem_resp;
  logic    dmem_req;
  logic    dmem_resp;
  logic    br_taken_mem;
  logic    ex_is_load;
  lc3b_reg ex_dest;
  logic    ex_dest_valid;
  lc3b_reg id_sr1;
  lc3b_reg id_sr2;
  logic    id_sr1_used;
  logic    id_sr2_used;

  // Latch controls back to the datapath
  logic load_pc;
  logic load_if_id;
  logic inject_nop_if_id;
  logic squash_if_id;
  logic load_id_ex;
  logic flush_id_ex;
  logic load_ex_mem;
  logic flush_ex_mem;
  logic load_mem_wb;

  modport master (
    output imem_resp, dmem_req, dmem_resp, br_taken_mem,
    output ex_is_load, ex_dest, ex_dest_valid,
    output id_sr1, id_sr2, id_sr1_used, id_sr2_used,
    input  load_pc, load_if_id, inject_nop_if_id, squash_if_id,
    input  load_id_ex, flush_id_ex, load_ex_mem, flush_ex_mem, load_mem_wb
  );

  modport slave (
    input  imem_resp, dmem_req, dmem_resp, br_taken_mem,
    input  ex_is_load, ex_dest, ex_dest_valid,
    input  id_sr1, id_sr2, id_sr1_used, id_sr2_used,
    output load_pc, load_if_id, inject_nop_if_id, squash_if_id,
    output load_id_ex, flush_id_ex, load_ex_mem, flush_ex_mem, load_mem_wb
  );

endinterface

// File: rtl/pipeline_control_load_use_detect.sv
// -----------------------------------------------------------------------------
// pipeline_control_load_use_detect
//   Combinational load-use hazard detector: flags when the load in EX writes
//   a register that the ID-stage instruction actually reads.
//
//   Ports:
//     ex_is_load, ex_dest_valid, ex_dest : EX-stage load and its destination
//     id_sr1/id_sr2, id_sr1_used/_used   : ID-stage sources and read enables
//     hazard                             : one bubble required this cycle
// -----------------------------------------------------------------------------
module pipeline_control_load_use_detect
  import pipeline_control_pkg::*;
(
  input  logic    ex_is_load,
  input  logic    ex_dest_valid,
  input  lc3b_reg ex_dest,
  input  lc3b_reg id_sr1,
  input  logic    id_sr1_used,
  input  lc3b_reg id_sr2,
  input  logic    id_sr2_used,
  output logic    hazard
);

  logic sr1_match;
  logic sr2_match;

  // Unused source fields may hold garbage bits, so the read enables gate
  // each compare.
  assign sr1_match = id_sr1_used && (id_sr1 == ex_dest);
  assign sr2_match = id_sr2_used && (id_sr2 == ex_dest);
  assign hazard    = ex_is_load && ex_dest_valid && (sr1_match || sr2_match);

endmodule

// File: rtl/pipeline_control.sv
// -----------------------------------------------------------------------------
// pipeline_control
//   Stall/flush sequencer for the 5-stage LC-3b pipeline. Controls are
//   combinational from the FSM state and the current status inputs.
//
//   Ports:
//     clk, reset     : clock, synchronous active-high reset
//     pif (slave)    : status inputs and latch control outputs
//     dbg_state      : current FSM state
//     stall_cycles   : cycles with load_pc low outside reset/INIT (saturating)
//     flush_events   : applied redirects (saturating)
//   The two counters exist only when PIPE_PERF_CNT_EN is defined.
//
//   Priority in RUN/DMEM_WAIT: D-stall > redirect > load-use > I-stall.
// -----------------------------------------------------------------------------
module pipeline_control
  import pipeline_control_pkg::*;
#(
  parameter int STALL_CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  pipeline_control_if.slave  pif,
  output pipe_ctrl_state_t   dbg_state
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic [STALL_CNT_W-1:0] flush_events
`endif
);

  if (STALL_CNT_W < 1) begin : g_bad_cnt_w
    $error("STALL_CNT_W must be at least 1");
  end

  pipe_ctrl_state_t state_q;
  pipe_ctrl_state_t state_d;
  pipe_ctrl_t       ctrl;
  logic             hazard;
  logic             dstall;

  pipeline_control_load_use_detect u_load_use_detect (
    .ex_is_load    (pif.ex_is_load),
    .ex_dest_valid (pif.ex_dest_valid),
    .ex_dest       (pif.ex_dest),
    .id_sr1        (pif.id_sr1),
    .id_sr1_used   (pif.id_sr1_used),
    .id_sr2        (pif.id_sr2),
    .id_sr2_used   (pif.id_sr2_used),
    .hazard        (hazard)
  );

  assign dstall = pif.dmem_req && !pif.dmem_resp;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    case (state_q)
      INIT: begin
        // Downstream latches keep loading NOPs until the first fetch lands.
        ctrl.inject_nop_if_id = 1'b1;
        ctrl.load_id_ex       = 1'b1;
        ctrl.flush_id_ex      = 1'b1;
        ctrl.load_ex_mem      = 1'b1;
        ctrl.flush_ex_mem     = 1'b1;
        ctrl.load_mem_wb      = 1'b1;
        ctrl.load_pc          = pif.imem_resp;
        ctrl.load_if_id       = pif.imem_resp;
        if (pif.imem_resp) begin
          state_d = RUN;
        end
      end

      RUN, DMEM_WAIT: begin
        if (dstall) begin
          // Whole pipeline frozen; ctrl stays all-zero.
          state_d = DMEM_WAIT;
        end else if (pif.br_taken_mem && pif.imem_resp) begin
          ctrl    = ctrl_redirect();
          state_d = RUN;
        end else if (pif.br_taken_mem) begin
          // Fetch of the wrong-path instruction still in flight; hold
          // everything so the redirect can be applied once it lands.
          state_d = REDIR_WAIT;
        end else if (hazard) begin
          // IF and ID hold, one bubble enters EX, the load moves on to MEM.
          ctrl.flush_id_ex = 1'b1;
          ctrl.load_ex_mem = 1'b1;
          ctrl.load_mem_wb = 1'b1;
          state_d          = RUN;
        end else if (!pif.imem_resp) begin
          // IF/ID keeps its instruction but ID presents a NOP so the held
          // instruction is not issued twice.
          ctrl.inject_nop_if_id = 1'b1;
          ctrl.load_id_ex       = 1'b1;
          ctrl.load_ex_mem      = 1'b1;
          ctrl.load_mem_wb      = 1'b1;
          state_d               = RUN;
        end else begin
          ctrl    = ctrl_normal();
          state_d = RUN;
        end
      end

      REDIR_WAIT: begin
        if (!pif.br_taken_mem) begin
          // Protocol violation (MEM should be frozen); recover to RUN.
          state_d = RUN;
        end else if (pif.imem_resp) begin
          ctrl    = ctrl_redirect();
          state_d = RUN;
        end
      end

      default: begin
        state_d = INIT;
      end
    endcase

    if (reset) begin
      ctrl = ctrl_reset();
    end
  end

  assign pif.load_pc          = ctrl.load_pc;
  assign pif.load_if_id       = ctrl.load_if_id;
  assign pif.inject_nop_if_id = ctrl.inject_nop_if_id;
  assign pif.squash_if_id     = ctrl.squash_if_id;
  assign pif.load_id_ex       = ctrl.load_id_ex;
  assign pif.flush_id_ex      = ctrl.flush_id_ex;
  assign pif.load_ex_mem      = ctrl.load_ex_mem;
  assign pif.flush_ex_mem     = ctrl.flush_ex_mem;
  assign pif.load_mem_wb      = ctrl.load_mem_wb;
  assign dbg_state            = state_q;

`ifdef PIPE_PERF_CNT_EN
  localparam logic [STALL_CNT_W-1:0] CNT_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

  logic [STALL_CNT_W-1:0] stall_q;
  logic [STALL_CNT_W-1:0] flush_q;
  logic                   stall_evt;
  logic                   flush_evt;

  assign stall_evt = (state_q != INIT) && !ctrl.load_pc;
  // squash_if_id is raised only by an applied redirect.
  assign flush_evt = ctrl.squash_if_id;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_evt && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_ONE;
      end
      if (flush_evt && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_ONE;
      end
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`endif

  // MEM is frozen while waiting on the redirect fetch, so the branch must
  // still be visible.
  a_redir_held: assert property (@(posedge clk) disable iff (reset)
    (state_q == REDIR_WAIT) |-> pif.br_taken_mem);

  a_flush_ex_mem_loads: assert property (@(posedge clk) disable iff (reset)
    ctrl.flush_ex_mem |-> ctrl.load_ex_mem);

  // The load-use bubble is the only flush without the matching load.
  a_flush_id_ex_loads: assert property (@(posedge clk) disable iff (reset)
    (ctrl.flush_id_ex && !ctrl.load_id_ex) |-> hazard);

endmodule
